// File: rtl/pool_pkg.sv
// Shared constants and types for the 2x2 max-pooling scheduler.
package pool_pkg;

  localparam int PIX_MAP24     = 576;
  localparam int OUTS_MAP24    = 144;
  localparam int PIX_MAP8      = 64;
  localparam int OUTS_MAP8     = 16;
  localparam int DRAIN_MAX_DEF = 64;
  localparam int MAX_CH_DEF    = 16;

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, NEXT, FIN} state_t;

  function automatic int pix_of(input logic mode);
    return mode ? PIX_MAP8 : PIX_MAP24;
  endfunction

  function automatic int outs_of(input logic mode);
    return mode ? OUTS_MAP8 : OUTS_MAP24;
  endfunction

endpackage

// File: rtl/pool_scheduler_if.sv
// Feature-RAM read, pooling-core and output-RAM write signals of the scheduler.
interface pool_scheduler_if #(
  parameter int DW  = 8,
  parameter int RAW = 14,
  parameter int WAW = 12
);
  logic           rd_en;
  logic [RAW-1:0] rd_addr;
  logic [DW-1:0]  rd_data;
  logic           pool_ivalid;
  logic           pool_state;
  logic [DW-1:0]  pool_din;
  logic           pool_ovalid;
  logic [DW-1:0]  pool_dout;
  logic           wr_en;
  logic [WAW-1:0] wr_addr;
  logic [DW-1:0]  wr_data;

  modport master (
    output rd_en, rd_addr, pool_ivalid, pool_state, pool_din, wr_en, wr_addr, wr_data,
    input  rd_data, pool_ovalid, pool_dout
  );

  modport slave (
    input  rd_en, rd_addr, pool_ivalid, pool_state, pool_din, wr_en, wr_addr, wr_data,
    output rd_data, pool_ovalid, pool_dout
  );
endinterface

// File: rtl/pool_wr_agu.sv
// Output-RAM write path: write pointer, per-channel output count and wr_* registers.
module pool_wr_agu #(
  parameter int DW  = 8,
  parameter int WAW = 12,
  parameter int OCW = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           clr_ptr,
  input  logic           clr_cnt,
  input  logic           accept,
  input  logic           ovalid,
  input  logic [DW-1:0]  dout,
  output logic [OCW-1:0] out_cnt,
  output logic           wr_en,
  output logic [WAW-1:0] wr_addr,
  output logic [DW-1:0]  wr_data
);

  logic [WAW-1:0] ptr;
  logic           take;

  assign take = accept && ovalid;

  // wr_addr trails the pointer by one cycle, so it shows the next free slot once writes stop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr     <= '0;
      out_cnt <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= take;
      if (take) wr_data <= dout;
      if (clr_ptr) begin
        ptr     <= '0;
        wr_addr <= '0;
      end else begin
        wr_addr <= ptr;
        if (take) ptr <= ptr + 1'b1;
      end
      // A result arriving in the clearing cycle still counts toward the new channel.
      if (clr_cnt)   out_cnt <= OCW'(take);
      else if (take) out_cnt <= out_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pool_scheduler.sv
// Sequences the 2x2 max-pooling core over a multi-channel feature map, channel by channel.
module pool_scheduler
  import pool_pkg::*;
#(
  parameter int DW        = 8,
  parameter int RAW       = 14,
  parameter int WAW       = 12,
  parameter int MAX_CH    = MAX_CH_DEF,
  parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 mode,
  input  logic [4:0]           num_ch,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  pool_scheduler_if.master     bus
);

  localparam int PCW = $clog2(PIX_MAP24 + 1);
  localparam int OCW = $clog2(OUTS_MAP24 + 1);
  localparam int TW  = $clog2(DRAIN_MAX + 1);

  if (MAX_CH * PIX_MAP24 > 2 ** RAW) begin : g_raw_chk
    $error("RAW too narrow for MAX_CH channels of the 24x24 map");
  end

  state_t         state, state_nxt;
  logic           mode_q, ivalid_q, err_q;
  logic [4:0]     num_ch_q, ch_cnt;
  logic [PCW-1:0] pix_cnt;
  logic [TW-1:0]  tmr;
  logic [RAW-1:0] rd_addr_q;
  logic [OCW-1:0] out_cnt;
  logic           accept, rd_fire, drain_done, timeout, ch_last;

  assign accept     = (state == IDLE) && start;
  assign rd_fire    = (state == STREAM) && !hold;
  assign drain_done = (state == DRAIN) && (out_cnt >= OCW'(outs_of(mode_q)));
  assign timeout    = (state == DRAIN) && !drain_done && (tmr == TW'(DRAIN_MAX - 1));
  assign ch_last    = (ch_cnt + 5'd1) == num_ch_q;

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (rd_fire && pix_cnt == PCW'(pix_of(mode_q) - 1)) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = NEXT;
               else if (timeout) state_nxt = FIN;
      NEXT:    state_nxt = ch_last ? FIN : STREAM;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q    <= 1'b0;
      num_ch_q  <= 5'd0;
      ch_cnt    <= 5'd0;
      pix_cnt   <= '0;
      tmr       <= '0;
      rd_addr_q <= '0;
      ivalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ivalid_q <= rd_fire;
      if (accept) begin
        mode_q    <= mode;
        num_ch_q  <= (num_ch == 5'd0) ? 5'd1 : num_ch;
        ch_cnt    <= 5'd0;
        pix_cnt   <= '0;
        tmr       <= '0;
        rd_addr_q <= '0;
        err_q     <= 1'b0;
      end
      if (rd_fire) begin
        rd_addr_q <= rd_addr_q + 1'b1;
        pix_cnt   <= pix_cnt + 1'b1;
      end
      if (state == DRAIN) tmr <= tmr + 1'b1;
      if (timeout) err_q <= 1'b1;
      // Read address keeps running across channels; only per-channel counters restart.
      if (state == NEXT) begin
        pix_cnt <= '0;
        tmr     <= '0;
        ch_cnt  <= ch_cnt + 5'd1;
      end
    end
  end

  assign busy            = (state == STREAM) || (state == DRAIN) || (state == NEXT);
  assign done            = (state == FIN);
  assign err             = err_q;
  assign bus.rd_en       = rd_fire;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.pool_ivalid = ivalid_q;
  assign bus.pool_state  = mode_q;
  assign bus.pool_din    = ivalid_q ? bus.rd_data : '0;

  pool_wr_agu #(.DW(DW), .WAW(WAW), .OCW(OCW)) u_wr_agu (
    .clk     (clk),
    .rstn    (rstn),
    .clr_ptr (accept),
    .clr_cnt (accept || (state == NEXT)),
    .accept  (busy),
    .ovalid  (bus.pool_ovalid),
    .dout    (bus.pool_dout),
    .out_cnt (out_cnt),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data)
  );

endmodule

// File: tb/tb_pool_scheduler.sv
// Directed bench for pool_scheduler with a ramp feature RAM and a group-of-4 max core stub.
module tb_pool_scheduler;
  import pool_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       hold = 1'b0;
  logic [4:0] num_ch = 5'd0;
  logic       busy, done, err;

  pool_scheduler_if #(.DW(8), .RAW(14), .WAW(12)) bus ();

  pool_scheduler #(.DW(8), .RAW(14), .WAW(12), .MAX_CH(16), .DRAIN_MAX(64)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .mode   (mode),
    .num_ch (num_ch),
    .hold   (hold),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Feature RAM: each word holds the low byte of its address.
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= bus.rd_addr[7:0];

  // Core stub: one output per four inputs, carrying the max of that group.
  logic       core_en = 1'b1;
  logic [1:0] grp_cnt;
  logic [7:0] grp_max, cand;
  assign cand = (grp_cnt == 2'd0 || bus.pool_din > grp_max) ? bus.pool_din : grp_max;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grp_cnt         <= 2'd0;
      grp_max         <= 8'd0;
      bus.pool_ovalid <= 1'b0;
      bus.pool_dout   <= 8'd0;
    end else begin
      bus.pool_ovalid <= 1'b0;
      if (bus.pool_ivalid) begin
        grp_max <= cand;
        grp_cnt <= grp_cnt + 2'd1;
        if (grp_cnt == 2'd3 && core_en) begin
          bus.pool_ovalid <= 1'b1;
          bus.pool_dout   <= cand;
        end
      end
    end
  end

  // Monitor, sampled on the falling edge.
  logic        mon_clr = 1'b0;
  logic        exp_state = 1'b0;
  logic [13:0] exp_rd;
  int n_rd, n_iv, n_wr, n_done, n_busy, rd_bad, rd_hold, wa_bad, wd_bad, st_bad;

  always @(negedge clk) begin
    if (mon_clr) begin
      exp_rd = 14'd0;
      n_rd = 0; n_iv = 0; n_wr = 0; n_done = 0; n_busy = 0;
      rd_bad = 0; rd_hold = 0; wa_bad = 0; wd_bad = 0; st_bad = 0;
    end else begin
      if (bus.rd_en) begin
        if (bus.rd_addr !== exp_rd) rd_bad++;
        exp_rd = bus.rd_addr + 14'd1;
        n_rd++;
        if (hold) rd_hold++;
      end
      if (bus.pool_ivalid) n_iv++;
      if (bus.wr_en) begin
        if (bus.wr_addr !== 12'(n_wr)) wa_bad++;
        if (bus.wr_data !== 8'(4 * n_wr + 3)) wd_bad++;
        n_wr++;
      end
      if (done) n_done++;
      if (busy) begin
        n_busy++;
        if (bus.pool_state !== exp_state) st_bad++;
      end
    end
  end

  function automatic logic [63:0] out_vec();
    return 64'({busy, done, err, bus.rd_en, bus.rd_addr, bus.pool_ivalid, bus.pool_state,
                bus.pool_din, bus.wr_en, bus.wr_addr, bus.wr_data});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic start_job(input logic m, input logic [4:0] n);
    clear_mon();
    exp_state = m;
    mode      = m;
    num_ch    = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Waits for done; optionally toggles hold (every 3rd cycle) and injects a stray start.
  task automatic run_wait(input int budget, input bit tog, input int start_at, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tog) hold = (i % 3 == 2);
      start = (i == start_at);
      if (i == start_at) begin
        mode   = 1'b0;
        num_ch = 5'd5;
      end
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    hold  = 1'b0;
    start = 1'b0;
    check({tag, " done seen"}, 64'(ok), 64'd1);
    tick();
    tick();
  endtask

  initial begin
    bit found;

    repeat (3) tick();
    check("reset outputs", out_vec(), 64'd0);
    rstn = 1'b1;
    tick();

    // 8x8 map, one channel: 64 reads, 16 writes, busy = 64 stream + 3 drain + 1 next.
    start_job(1'b1, 5'd1);
    run_wait(300, 1'b0, -1, "m8c1");
    check("m8c1 reads", n_rd, 64);
    check("m8c1 rd addr seq", rd_bad, 0);
    check("m8c1 writes", n_wr, 16);
    check("m8c1 wr addr seq", wa_bad, 0);
    check("m8c1 wr data", wd_bad, 0);
    check("m8c1 done pulses", n_done, 1);
    check("m8c1 busy cycles", n_busy, 68);
    check("m8c1 final wr_addr", 64'(bus.wr_addr), 64'd16);
    check("m8c1 err", 64'(err), 64'd0);

    // 24x24 map, three channels: 1728 contiguous reads, 432 writes.
    start_job(1'b0, 5'd3);
    run_wait(2500, 1'b0, -1, "m24c3");
    check("m24c3 reads", n_rd, 1728);
    check("m24c3 rd addr seq", rd_bad, 0);
    check("m24c3 writes", n_wr, 432);
    check("m24c3 wr data", wd_bad, 0);
    check("m24c3 pool_state", st_bad, 0);
    check("m24c3 busy cycles", n_busy, 3 * (576 + 3 + 1));
    check("m24c3 final wr_addr", 64'(bus.wr_addr), 64'd432);

    // Backpressure: same results as an unheld run, never a read while held.
    start_job(1'b1, 5'd2);
    run_wait(800, 1'b1, -1, "hold");
    check("hold rd while held", rd_hold, 0);
    check("hold ivalid count", n_iv, 128);
    check("hold rd addr seq", rd_bad, 0);
    check("hold writes", n_wr, 32);
    check("hold wr data", wd_bad, 0);

    // A start mid-job (with different mode/num_ch) is ignored.
    start_job(1'b1, 5'd2);
    run_wait(400, 1'b0, 20, "restart");
    check("restart reads", n_rd, 128);
    check("restart rd addr seq", rd_bad, 0);
    check("restart writes", n_wr, 32);
    check("restart pool_state", st_bad, 0);
    check("restart busy cycles", n_busy, 136);
    check("restart done pulses", n_done, 1);
    check("restart final wr_addr", 64'(bus.wr_addr), 64'd32);

    // Silent core: drain times out after 64 cycles, err sticks until next start.
    core_en = 1'b0;
    start_job(1'b1, 5'd2);
    run_wait(400, 1'b0, -1, "stub");
    check("stub err set", 64'(err), 64'd1);
    check("stub done pulses", n_done, 1);
    check("stub busy cycles", n_busy, 64 + 64);
    check("stub writes", n_wr, 0);
    core_en = 1'b1;
    start_job(1'b1, 5'd1);
    check("stub err cleared on start", 64'(err), 64'd0);
    run_wait(300, 1'b0, -1, "post stub");
    check("post stub writes", n_wr, 16);
    check("post stub err", 64'(err), 64'd0);

    // Reset during channel 2 streaming abandons the job.
    start_job(1'b1, 5'd3);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.rd_en && bus.rd_addr == 14'd70) begin
        found = 1'b1;
        break;
      end
    end
    check("abort reached ch2", 64'(found), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("abort async outputs", out_vec(), 64'd0);
    check("abort fsm idle", 64'(dut.state), 64'(IDLE));
    repeat (3) tick();
    check("abort no done", n_done, 0);
    rstn = 1'b1;
    tick();
    start_job(1'b1, 5'd1);
    run_wait(300, 1'b0, -1, "after abort");
    check("after abort reads", n_rd, 64);
    check("after abort rd from 0", rd_bad, 0);
    check("after abort writes", n_wr, 16);
    check("after abort wr data", wd_bad, 0);

    // num_ch = 0 behaves as one channel.
    start_job(1'b1, 5'd0);
    run_wait(300, 1'b0, -1, "nch0");
    check("nch0 reads", n_rd, 64);
    check("nch0 writes", n_wr, 16);
    check("nch0 busy cycles", n_busy, 68);
    check("nch0 final wr_addr", 64'(bus.wr_addr), 64'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
